// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct constants and reset values for the core.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_JMP,
    NPC_JR
  } npc_src_e;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC select from the control transfer held in ID.
module npc_sel
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir_d,
  input  logic [31:0] pc4_d,
  input  logic        cmpout,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic        taken
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_br;
  logic       is_jmp;
  logic       is_jr;
  npc_src_e   src;

  assign op    = ir_d[31:26];
  assign funct = ir_d[5:0];

  // cmpout only matters for beq
  assign is_br  = (op == OP_BEQ) && cmpout;
  assign is_jmp = (op == OP_J) || (op == OP_JAL);
  assign is_jr  = (op == OP_SPECIAL) && (funct == FUNCT_JR);

  always_comb begin
    src = NPC_SEQ;
    unique case (1'b1)
      is_br:   src = NPC_BR;
      is_jmp:  src = NPC_JMP;
      is_jr:   src = NPC_JR;
      default: src = NPC_SEQ;
    endcase
  end

  always_comb begin
    npc = pc + 32'd4;
    case (src)
      NPC_BR:  npc = pc4_d + br_off(ir_d[15:0]);
      NPC_JMP: npc = {pc4_d[31:28], ir_d[25:0], 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = pc + 32'd4;
    endcase
  end

  assign taken = (src != NPC_SEQ);

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register and IF/ID pipeline register.
// Define BRANCH_FLUSH_EN to squash the delay slot on taken transfers.
module fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] imem_instr,
  input  logic        cmpout,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] ir_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc8_d,
  output logic        pc_misalign
);

  logic [31:0] npc;
  logic        taken;

  npc_sel u_npc_sel (
    .pc        (pc),
    .ir_d      (ir_d),
    .pc4_d     (pc4_d),
    .cmpout    (cmpout),
    .jr_target (jr_target),
    .npc       (npc),
    .taken     (taken)
  );

`ifdef BRANCH_FLUSH_EN
  logic [31:0] ir_next;
  assign ir_next = taken ? NOP_INSTR : imem_instr;
`else
  logic [31:0] ir_next;
  logic        unused_taken;
  assign ir_next      = imem_instr;
  assign unused_taken = taken;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_PC;
      ir_d  <= NOP_INSTR;
      pc4_d <= RESET_PC;
    end else if (!stall) begin
      pc    <= npc;
      ir_d  <= ir_next;
      pc4_d <= pc + 32'd4;
    end
  end

  assign pc8_d       = pc4_d + 32'd4;
  assign pc_misalign = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] imem_instr;
  logic        cmpout;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] ir_d;
  logic [31:0] pc4_d;
  logic [31:0] pc8_d;
  logic        pc_misalign;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_ir, m_pc4;

`ifdef BRANCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  localparam logic [31:0] DS   = 32'h2401_0001;
  localparam logic [31:0] BEQ3 = 32'h1000_0003;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .imem_instr  (imem_instr),
    .cmpout      (cmpout),
    .jr_target   (jr_target),
    .pc          (pc),
    .ir_d        (ir_d),
    .pc4_d       (pc4_d),
    .pc8_d       (pc8_d),
    .pc_misalign (pc_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: decode the held ID instruction and pick the next fetch.
  task automatic model_edge();
    logic [31:0] tgt;
    bit          tk;
    int          off;
    int unsigned op, fn;
    op  = m_ir >> 26;
    fn  = m_ir & 32'h3f;
    off = $signed(m_ir[15:0]);
    tk  = 1'b1;
    if (op == 4 && cmpout)
      tgt = m_pc4 + off * 4;
    else if (op == 2 || op == 3)
      tgt = (m_pc4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
    else if (op == 0 && fn == 8)
      tgt = jr_target;
    else begin
      tk  = 1'b0;
      tgt = m_pc + 4;
    end
    if (!reset) begin
      m_pc  = 32'h3000;
      m_ir  = 32'h0;
      m_pc4 = 32'h3000;
    end else if (!stall) begin
      m_pc4 = m_pc + 4;
      m_pc  = tgt;
      m_ir  = (FLUSH && tk) ? 32'h0 : imem_instr;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    cmpout = 1'b0;
    imem_instr = 32'h0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    imem_instr = 32'h0;
    cmpout = 1'b0;
    jr_target = 32'h0;
    m_pc = 0; m_ir = 0; m_pc4 = 0;

    // reset and sequential fetch
    do_reset();
    check("rst_pc", pc, 32'h3000);
    check("rst_ir", ir_d, 32'h0);
    check("rst_pc4", pc4_d, 32'h3000);
    check("rst_mis", {31'b0, pc_misalign}, 32'h0);
    step();
    check("seq_pc1", pc, 32'h3004);
    check("seq_pc4_1", pc4_d, 32'h3004);
    step();
    check("seq_pc2", pc, 32'h3008);
    check("seq_pc4_2", pc4_d, 32'h3008);

    // beq taken
    do_reset();
    imem_instr = BEQ3;
    step();
    check("beq_ds_pc", pc, 32'h3004);
    check("beq_id", ir_d, BEQ3);
    imem_instr = DS;
    cmpout = 1'b1;
    step();
    check("beq_tgt", pc, 32'h3010);
    check("beq_ds_ir", ir_d, FLUSH ? 32'h0 : DS);
    check("beq_pc4", pc4_d, 32'h3008);

    // beq not taken
    do_reset();
    imem_instr = BEQ3;
    step();
    imem_instr = DS;
    cmpout = 1'b0;
    step();
    check("beqnt_pc", pc, 32'h3008);
    check("beqnt_ir", ir_d, DS);

    // jal
    do_reset();
    imem_instr = 32'h0C00_0C40;
    step();
    check("jal_ds_pc", pc, 32'h3004);
    check("jal_pc8", pc8_d, 32'h3008);
    imem_instr = 32'h0;
    step();
    check("jal_tgt", pc, 32'h3100);

    // jr misaligned
    do_reset();
    imem_instr = 32'h03E0_0008;
    step();
    jr_target = 32'h3002;
    imem_instr = 32'h0;
    step();
    check("jr_pc", pc, 32'h3002);
    check("jr_mis", {31'b0, pc_misalign}, 32'h1);

    // stall with taken beq in ID
    do_reset();
    imem_instr = BEQ3;
    step();
    cmpout = 1'b1;
    stall = 1'b1;
    imem_instr = DS;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_pc", pc, 32'h3004);
      check("stl_ir", ir_d, BEQ3);
      check("stl_pc4", pc4_d, 32'h3004);
    end
    stall = 1'b0;
    step();
    check("stl_rel_pc", pc, 32'h3010);
    imem_instr = 32'h0;
    step();
    check("stl_once_pc", pc, 32'h3014);

    // reset mid-stall
    do_reset();
    imem_instr = BEQ3;
    step();
    cmpout = 1'b1;
    stall = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("rst_stl_pc", pc, 32'h3000);
    check("rst_stl_ir", ir_d, 32'h0);

    // j: squash only when flush is built in
    do_reset();
    imem_instr = 32'h0800_0C40;
    step();
    imem_instr = DS;
    step();
    check("j_tgt", pc, 32'h3100);
    check("j_ir", ir_d, FLUSH ? 32'h0 : DS);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1: imem_instr = {6'd4, 10'($urandom), 16'($urandom)};
        2:    imem_instr = {6'd2, 26'($urandom)};
        3:    imem_instr = {6'd3, 26'($urandom)};
        4:    imem_instr = {6'd0, 20'($urandom), 6'd8};
        default: imem_instr = $urandom;
      endcase
      cmpout    = 1'($urandom);
      jr_target = ($urandom_range(0, 3) == 0) ? $urandom
                                               : ($urandom & 32'hFFFF_FFFC);
      stall     = ($urandom_range(0, 4) == 0);
      reset     = ($urandom_range(0, 49) != 0);
      step();
      check("r_pc", pc, m_pc);
      check("r_ir", ir_d, m_ir);
      check("r_pc4", pc4_d, m_pc4);
      check("r_pc8", pc8_d, m_pc4 + 32'd4);
      check("r_mis", {31'b0, pc_misalign}, {31'b0, m_pc[1:0] != 2'b00});
    end

    // wrap at top of address space
    do_reset();
    imem_instr = 32'h03E0_0008;
    step();
    jr_target = 32'hFFFF_FFFC;
    imem_instr = 32'h0;
    step();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_zero", pc, 32'h0);
    check("wrap_pc4", pc4_d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Holds the PC, drives instruction-memory address, latches fetched instruction and PC+4 into ID.
- Resolves next PC from ID-stage control transfers: beq via the branch comparator result `cmpout`, j/jal, jr.
- Directly downstream of the branch comparator: consumes its single-bit taken result.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, value placed in IR_D on reset/flush (sll $0,$0,0).

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- stall  in  1  hazard-unit stall; hold PC and IF/ID
- imem_instr  in  32  instruction at address PC (combinational imem read)
- cmpout  in  1  branch comparator result for instruction currently in ID
- jr_target  in  32  forwarded rs value for jr in ID
- pc  out  32  fetch address to imem
- ir_d  out  32  IF/ID instruction register
- pc4_d  out  32  IF/ID PC+4
- pc8_d  out  32  pc4_d+4, jal link value
- pc_misalign  out  1  pc[1:0] != 0

Behaviour:
- One clock; reset synchronous, active-low; reset sampled on rising clk edge.
  - reset=0: pc<=RESET_PC, ir_d<=NOP_INSTR, pc4_d<=RESET_PC.
  - Reset overrides stall and any control transfer.
- ID decode from ir_d: op=ir_d[31:26], funct=ir_d[5:0], imm16=ir_d[15:0], index=ir_d[25:0].
- npc priority (first match wins):
  - beq (op 000100) and cmpout=1: pc4_d + (sign_ext(imm16)<<2).
  - j (000010) / jal (000011): {pc4_d[31:28], index, 2'b00}.
  - jr (op 000000, funct 001000): jr_target, unmodified; misalignment reported via pc_misalign once loaded.
  - else: pc+4.
- cmpout ignored unless op is beq.
- Clocked update, stall=0: pc<=npc; ir_d<=imem_instr; pc4_d<=pc+4.
  - Instruction after a branch/jump (delay slot) executes normally.
- stall=1: pc, ir_d, pc4_d hold.
  - The ID control transfer is not applied this cycle.
  - The held ID instruction re-evaluates npc when the stall drops, so the decision is applied exactly once.
- Arithmetic: all adds 32-bit modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Latency:
  - Sequential fetch: one instruction per cycle.
  - Taken branch/jump in ID: target fetched the cycle after the delay-slot fetch, i.e. 1 delay slot.
- pc8_d and pc_misalign are combinational from registers; no extra state.

Optional Feature:
- Macro: BRANCH_FLUSH_EN.
- Defined: a non-stalled cycle with a taken control transfer in ID loads ir_d<=NOP_INSTR and pc4_d<=pc+4. The delay slot is squashed and pc still goes to the target.
- Undefined: MIPS delay-slot semantics as above; no squash.

Decomposition:
- Shared package/header mips_defs:
  - Opcode/funct constants OP_BEQ, OP_J, OP_JAL, OP_SPECIAL, FUNCT_JR.
  - RESET_PC default and NOP_INSTR, shared with the decoder and the branch comparator.
- One natural sub-module: npc_sel, purely combinational.
  - Inputs: pc, ir_d, pc4_d, cmpout, jr_target.
  - Output: npc.
- PC and IF/ID registers stay in fetch_unit.

Test Plan:
- Reset then free-run, imem returns nops:
  - After reset, pc=3000, ir_d=0.
  - Following edges: pc=3004, 3008; pc4_d tracks previous pc+4.
- beq at 3000 with imm16=0x0003, cmpout=1 in ID:
  - Delay slot 3004 fetched.
  - Next pc = 3004+12 = 3010.
  - With cmpout=0, pc=3008.
- jal at 3000 with index=0x0000C40:
  - pc goes 3004 then 0x00003100.
  - pc8_d=3008 while jal in ID.
- jr in ID with jr_target=0x0000_3002:
  - pc becomes 3002, pc_misalign=1.
- stall=1 for 3 cycles while beq taken sits in ID:
  - pc, ir_d, pc4_d frozen.
  - On release, target loaded exactly once; no double-advance.
- reset=0 asserted mid-stall with branch in ID:
  - Next edge pc=3000, ir_d=0.
- BRANCH_FLUSH_EN defined, taken j in ID:
  - ir_d=0 on next edge.
  - pc=target.
